// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-I subset CPU: fetch, decode, execute, memory, writeback in one clock.
// Ports: clk (rising edge), rst_n (async, active HIGH, clears PC only).
package scc_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    dst_rd;
    logic    link;
    logic    use_imm;
    logic    zext;
    logic    mem_read;
    logic    mem_write;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jr;
    alu_op_e alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
endpackage

// Program counter register; asynchronously cleared by reset.
// Ports: clk, rst_n (active high), next_pc in, pc_out out.
module pc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_out
);
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) pc_out <= 32'd0;
    else       pc_out <= next_pc;
  end
endmodule

// 256-word instruction store, loaded from outside through the hierarchy.
// Ports: clk, addr (word index), instr (combinational read).
module instr_mem (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] memory [0:255];

  // No write port: contents are held and only changed by an external loader.
  always_ff @(posedge clk) begin
    memory <= memory;
  end

  assign instr = memory[addr];
endmodule

// 32-byte little-endian data memory, word-granular access.
// Ports: clk, we, word_addr (addr[4:2]), wdata, rdata (combinational).
module data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] memory [0:31];
  logic [4:0] base;

  assign base = {word_addr, 2'b00};

  assign rdata = {memory[base + 5'd3], memory[base + 5'd2],
                  memory[base + 5'd1], memory[base]};

  always_ff @(posedge clk) begin
    if (we) begin
      memory[base]        <= wdata[7:0];
      memory[base + 5'd1] <= wdata[15:8];
      memory[base + 5'd2] <= wdata[23:16];
      memory[base + 5'd3] <= wdata[31:24];
    end
  end
endmodule

// 32x32 register file, two combinational read ports, one write port.
// Ports: clk, ra1/ra2 -> rd1/rd2, we/wa/wd write at posedge.
module reg_file (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] register [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : register[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : register[ra2];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) register[wa] <= wd;
  end
endmodule

// Main decoder: opcode/funct to control bundle.
// Unknown encodings leave every control low, which is a NOP.
module ctrl_decode
  import scc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (1'b1)
      (op == OP_R): begin
        ctrl.dst_rd = 1'b1;
        unique case (1'b1)
          (funct == FN_ADD): begin
            ctrl.reg_write = 1'b1;
          end
          (funct == FN_SUB): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SUB;
          end
          (funct == FN_AND): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_AND;
          end
          (funct == FN_OR): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OR;
          end
          (funct == FN_SLT): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SLT;
          end
          (funct == FN_SLL): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SLL;
          end
          (funct == FN_JR): begin
            ctrl.jr = 1'b1;
          end
          default: ;
        endcase
      end
      (op == OP_ADDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
      end
      (op == OP_SLTI): begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      (op == OP_ANDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.zext      = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      (op == OP_ORI): begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.zext      = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      (op == OP_LUI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_LUI;
      end
      (op == OP_LW): begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      (op == OP_SW): begin
        ctrl.use_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      (op == OP_BEQ): ctrl.beq  = 1'b1;
      (op == OP_BNE): ctrl.bne  = 1'b1;
      (op == OP_J):   ctrl.jump = 1'b1;
      (op == OP_JAL): begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module single_cycle_cpu
  import scc_pkg::*;
(
  input logic clk,
  input logic rst_n
);
  ctrl_t       ctrl;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic [4:0]  wa;
  logic        taken;
  logic        rf_we;
  logic        dm_we;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  pc_reg PC (
    .clk     (clk),
    .rst_n   (rst_n),
    .next_pc (next_pc),
    .pc_out  (pc)
  );

  instr_mem Instr_Memory (
    .clk   (clk),
    .addr  (pc[9:2]),
    .instr (instr)
  );

  ctrl_decode u_dec (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  // Writes are suppressed while reset is held.
  assign rf_we = ctrl.reg_write & ~rst_n;
  assign dm_we = ctrl.mem_write & ~rst_n;

  assign wa = ctrl.link   ? 5'd31 :
              ctrl.dst_rd ? rd    : rt;

  reg_file Register_File (
    .clk (clk),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (rf_we),
    .wa  (wa),
    .wd  (wb_data)
  );

  assign imm_ext = ctrl.zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl.use_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = 32'd0;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_y = rt_val << shamt;
      ALU_LUI: alu_y = {imm, 16'd0};
      default: alu_y = 32'd0;
    endcase
  end

  data_mem Data_Memory (
    .clk       (clk),
    .we        (dm_we),
    .word_addr (alu_y[4:2]),
    .wdata     (rt_val),
    .rdata     (mem_rdata)
  );

  assign pc4 = pc + 32'd4;

  assign wb_data = ctrl.link     ? pc4       :
                   ctrl.mem_read ? mem_rdata : alu_y;

  assign taken = (ctrl.beq & (rs_val == rt_val)) |
                 (ctrl.bne & (rs_val != rt_val));

  always_comb begin
    next_pc = pc4;
    unique case (1'b1)
      ctrl.jr:   next_pc = rs_val;
      ctrl.jump: next_pc = {pc4[31:28], target, 2'b00};
      taken:     next_pc = pc4 + {imm_ext[29:0], 2'b00};
      default:   next_pc = pc4;
    endcase
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Self-checking bench for single_cycle_cpu: loads small programs into
// instruction memory, runs fixed cycle counts and scores architectural state.
module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_REG  = 0;
  localparam int K_BYTE = 1;
  localparam int K_PC   = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  single_cycle_cpu dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_i(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input int kind, input int idx,
                          input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG:   obs = dut.Register_File.register[e.idx];
        K_BYTE:  obs = {24'd0, dut.Data_Memory.memory[e.idx]};
        default: obs = dut.PC.pc_out;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.Instr_Memory.memory[i] = 32'd0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.Instr_Memory.memory[idx] = w;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_imem();
  endtask

  initial begin
    #1 rst_n = 1'b1;
    #1;
    expect_v("reset_pc", K_PC, 0, 32'd0);
    drain();

    // ALU and edge cases
    hold_reset();
    put(0,  i_i(6'h08, 0, 8, 16'd5));
    put(1,  i_i(6'h08, 0, 9, 16'hFFFD));
    put(2,  r_i(6'h20, 8, 9, 10, 0));
    put(3,  r_i(6'h22, 9, 8, 11, 0));
    put(4,  r_i(6'h2A, 9, 8, 12, 0));
    put(5,  i_i(6'h08, 0, 0, 16'd7));
    put(6,  i_i(6'h0F, 0, 14, 16'h1234));
    put(7,  i_i(6'h0D, 14, 14, 16'hFFFF));
    put(8,  i_i(6'h0F, 0, 15, 16'h7FFF));
    put(9,  i_i(6'h0D, 15, 15, 16'hFFFF));
    put(10, i_i(6'h08, 15, 15, 16'd1));
    put(11, r_i(6'h00, 0, 8, 18, 4));
    put(12, i_i(6'h0C, 9, 19, 16'h00F0));
    put(13, i_i(6'h0A, 9, 20, 16'd0));
    put(14, r_i(6'h25, 8, 9, 21, 0));
    put(15, r_i(6'h24, 8, 9, 22, 0));
    put(16, 32'hFC00_0000);
    put(17, r_i(6'h3F, 9, 9, 8, 0));
    put(18, r_i(6'h2A, 8, 9, 13, 0));
    expect_v("addi_pos", K_REG, 8,  32'd5);
    expect_v("addi_neg", K_REG, 9,  32'hFFFF_FFFD);
    expect_v("add",      K_REG, 10, 32'd2);
    expect_v("sub",      K_REG, 11, 32'hFFFF_FFF8);
    expect_v("slt_t",    K_REG, 12, 32'd1);
    expect_v("slt_f",    K_REG, 13, 32'd0);
    expect_v("r0_zero",  K_REG, 0,  32'd0);
    expect_v("lui_ori",  K_REG, 14, 32'h1234_FFFF);
    expect_v("addi_wrap",K_REG, 15, 32'h8000_0000);
    expect_v("sll",      K_REG, 18, 32'h50);
    expect_v("andi_zx",  K_REG, 19, 32'hF0);
    expect_v("slti",     K_REG, 20, 32'd1);
    expect_v("or",       K_REG, 21, 32'hFFFF_FFFD);
    expect_v("and",      K_REG, 22, 32'd5);
    expect_v("alu_pc",   K_PC,  0,  32'd76);
    start();
    run(19);
    drain();

    // Memory
    hold_reset();
    put(0,  i_i(6'h08, 0, 1, 16'd5));
    put(1,  i_i(6'h2B, 0, 1, 16'd0));
    put(2,  i_i(6'h23, 0, 16, 16'd0));
    put(3,  i_i(6'h2B, 0, 16, 16'd8));
    put(4,  i_i(6'h23, 0, 17, 16'd8));
    put(5,  i_i(6'h0F, 0, 2, 16'hAABB));
    put(6,  i_i(6'h0D, 2, 2, 16'hCCDD));
    put(7,  i_i(6'h2B, 0, 2, 16'd12));
    put(8,  i_i(6'h23, 0, 23, 16'd2));
    put(9,  i_i(6'h23, 0, 24, 16'd35));
    put(10, i_i(6'h08, 0, 3, 16'd44));
    put(11, i_i(6'h23, 3, 25, 16'hFFE0));
    expect_v("lw0",      K_REG,  16, 32'd5);
    expect_v("lw8",      K_REG,  17, 32'd5);
    expect_v("b8",       K_BYTE, 8,  32'h05);
    expect_v("b9",       K_BYTE, 9,  32'h00);
    expect_v("b10",      K_BYTE, 10, 32'h00);
    expect_v("b11",      K_BYTE, 11, 32'h00);
    expect_v("le_lo",    K_BYTE, 12, 32'hDD);
    expect_v("le_hi",    K_BYTE, 15, 32'hAA);
    expect_v("lw_unal",  K_REG,  23, 32'd5);
    expect_v("lw_wrap",  K_REG,  24, 32'd5);
    expect_v("lw_negof", K_REG,  25, 32'hAABB_CCDD);
    expect_v("mem_pc",   K_PC,   0,  32'd48);
    start();
    run(12);
    drain();

    // Branches
    hold_reset();
    put(0, i_i(6'h04, 0, 0, 16'd2));
    put(1, i_i(6'h08, 0, 4, 16'd1));
    put(2, i_i(6'h08, 0, 4, 16'd2));
    put(3, i_i(6'h05, 0, 0, 16'd2));
    put(4, i_i(6'h08, 0, 4, 16'd9));
    put(5, i_i(6'h04, 0, 0, 16'hFFFF));
    start();
    expect_v("beq_taken", K_PC, 0, 32'd12);
    run(1);
    drain();
    expect_v("bne_fall", K_PC, 0, 32'd16);
    run(1);
    drain();
    expect_v("after_br", K_REG, 4, 32'd9);
    expect_v("loop_pc1", K_PC,  0, 32'd20);
    run(1);
    drain();
    expect_v("self_loop", K_PC, 0, 32'd20);
    run(2);
    drain();

    // Calls and jumps
    hold_reset();
    put(2,  j_i(6'h03, 26'h10));
    put(3,  i_i(6'h08, 0, 5, 16'h77));
    put(4,  j_i(6'h02, 26'h20));
    put(16, r_i(6'h08, 31, 0, 0, 0));
    start();
    expect_v("jal_pc",  K_PC,  0,  32'h40);
    expect_v("jal_r31", K_REG, 31, 32'd12);
    run(3);
    drain();
    expect_v("jr_pc", K_PC, 0, 32'd12);
    run(1);
    drain();
    expect_v("ret_body", K_REG, 5, 32'h77);
    expect_v("ret_pc",   K_PC,  0, 32'd16);
    run(1);
    drain();
    expect_v("j_pc", K_PC, 0, 32'h80);
    run(1);
    drain();

    // Asynchronous reset mid-program
    #2 rst_n = 1'b1;
    #1;
    expect_v("async_rst_pc", K_PC, 0, 32'd0);
    drain();
    @(negedge clk);
    put(0, i_i(6'h08, 0, 5, 16'h55));
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_keep_r5",  K_REG,  5,  32'h77);
    expect_v("rst_keep_r31", K_REG,  31, 32'd12);
    expect_v("rst_keep_b8",  K_BYTE, 8,  32'h05);
    expect_v("rst_hold_pc",  K_PC,   0,  32'd0);
    drain();
    start();
    expect_v("restart_r5", K_REG, 5, 32'h55);
    expect_v("restart_pc", K_PC,  0, 32'd4);
    run(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
